// File: rtl/seq_multiplier_pkg.sv
// Shared CPU definitions used by the multiplier: FSM state encoding and the
// default datapath width.
package seq_multiplier_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 sequential shift-add multiplier, one multiplier bit per RUN cycle.
// Signed operands are reduced to magnitudes and the product sign fixed at the end.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mul_state_t state, state_next;

    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_sum, product;
    logic               last;

    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is
    // exactly its magnitude when read as unsigned.
    assign mag_a   = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b   = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign product = neg ? -acc_sum : acc_sum;
    assign last    = (cnt == WIDTH'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mplier <= mag_b;
                    acc    <= '0;
                    cnt    <= '0;
                    neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (last) begin
                        cnt      <= '0;
                        {hi, lo} <= product;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: stimulus pushes expected products into a
// queue, a monitor pops and compares them on every done pulse.
module tb_seq_multiplier;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a, op_b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    logic [2*W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_done: got hi/lo 0x%0h, expected no done", {hi, lo});
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    n_miss++;
                    $display("FAIL product: got 0x%0h, expected 0x%0h", {hi, lo}, e);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first idle cycle after done.
    // inj_k > 0 fires an extra start with junk operands at that RUN cycle.
    task automatic do_op(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] expv, input int inj_k);
        int busy_cnt, done_at;
        busy_cnt = 0;
        done_at  = 0;
        signed_op = s; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        // scramble inputs after launch; the operation must use latched values
        op_a = ~a; op_b = a ^ b; signed_op = ~s;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_k) begin
                start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
            if (!busy) break;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_latency"}, done_at, W + 1);
        check({name, "_busy_cycles"}, busy_cnt, W + 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hilo", {hi, lo}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op("u_max",      1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
        do_op("s_mixed",    1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 0);
        do_op("u_mixed",    1'b0, 16'hFFFD, 16'h0005, 32'h0004_FFF1, 0);
        do_op("s_zero",     1'b1, 16'h0000, 16'h1234, 32'h0000_0000, 0);
        do_op("s_minmin",   1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 0);
        do_op("s_maxmin",   1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 0);
        do_op("s_negneg",   1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 0);
        do_op("u_shift",    1'b0, 16'h1234, 16'h0010, 32'h0001_2340, 0);
        do_op("ignored_st", 1'b0, 16'h0064, 16'h0064, 32'h0000_2710, 5);
        // issued in the idle cycle right after done
        do_op("back2back",  1'b1, 16'h0002, 16'hFFFF, 32'hFFFF_FFFE, 0);

        // reset at RUN cycle 8 abandons the operation with no done pulse
        signed_op = 1'b0; op_a = 16'h1111; op_b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hilo", {hi, lo}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done_busy", busy, 0);
        do_op("after_rst",  1'b0, 16'h0003, 16'h0007, 32'h0000_0015, 0);

        repeat (25) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a multiply; driven from the control unit's mul AND exe.
REQ-005 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 op_a  input  WIDTH  multiplicand, sampled with start.
REQ-007 op_b  input  WIDTH  multiplier, sampled with start.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; hi/lo are valid in this cycle.
REQ-010 hi  output  WIDTH  upper half of the last completed product; feeds write-back source HI.
REQ-011 lo  output  WIDTH  lower half of the last completed product; feeds write-back source LO.

Function
REQ-012 FSM states:
- IDLE: waits for start.
- RUN: performs the iterations.
- DONE: presents the result for one cycle.
REQ-013 Transitions:
- IDLE->RUN: on a rising edge with start=1.
- RUN->DONE: after exactly WIDTH RUN cycles.
- DONE->IDLE: unconditionally.
REQ-014 On IDLE->RUN the block latches op_a, op_b and signed_op; later input changes have no effect on the operation.
REQ-015 Algorithm: radix-2 shift-add on operand magnitudes, one multiplier bit per RUN cycle; a WIDTH-bit iteration counter counts from 0 to WIDTH-1.
REQ-016 Signed mode:
- Take the magnitudes of both operands.
- Negate the 2*WIDTH-bit result if exactly one operand is negative.
- The magnitude of the most-negative value is (2^(WIDTH-1)), held unsigned without overflow.
REQ-017 hi/lo update on the RUN->DONE edge only; they hold that value until the next RUN->DONE edge or reset.
REQ-018 Latency: start sampled at edge N -> done=1 during cycle N+WIDTH+1 -> busy=0 from cycle N+WIDTH+2.
REQ-019 A start pulse in RUN or DONE is ignored and does not queue.
REQ-020 A start pulse in the cycle after done (IDLE) is accepted; back-to-back throughput is one multiply per WIDTH+2 cycles.
REQ-021 Zero operand: takes the full latency, with no early termination; the result is 0.
REQ-022 The product is exact for all operand pairs in both modes; there is no overflow or saturation.

Reset
REQ-023 rst=1 forces, immediately and regardless of clk:
- state=IDLE
- busy=0, done=0
- hi=0, lo=0
- counter=0
- internal accumulators = 0
REQ-024 Reset during RUN or DONE abandons the operation; no done pulse is produced for it.
REQ-025 After rst deasserts, the first rising edge with start=1 begins a new operation normally.

Structure
REQ-026 The shared CPU package holds:
- the FSM state encoding (IDLE, RUN, DONE);
- the default WIDTH constant, matching the CPU data width.
REQ-027 Single module; no sub-module. The counter, shift-add datapath and sign correction are local.
REQ-028 The control unit keeps wb/PC advance stalled while busy=1; that gating is outside this block.

Verification (WIDTH=16)
REQ-029 Unsigned maximum: signed_op=0, a=0xFFFF, b=0xFFFF, start pulse -> done in cycle 17 after start; hi=0xFFFE, lo=0x0001.
REQ-030 Signed mixed and zero cases:
- signed_op=1, a=0xFFFD (-3), b=0x0005 -> hi=0xFFFF, lo=0xFFF1 (-15).
- a=0 with any b -> hi=0, lo=0, at full latency.
REQ-031 Signed corner: signed_op=1, a=b=0x8000 -> hi=0x4000, lo=0x0000.
REQ-032 Busy handling:
- Start again at RUN cycle 5 with different operands -> ignored; the first result is unchanged.
- A new start in the cycle after done -> accepted.
- busy is high for exactly 17 cycles per op.
REQ-033 Reset mid-operation: assert rst at RUN cycle 8 -> busy=0, hi=lo=0 at once, no done pulse; the next op (a=0x0003, b=0x0007, unsigned) -> lo=0x0015, hi=0.
